// File: rtl/program_sequencer.sv
// Program-counter stage feeding the instruction decoder: computes the fetch
// address, registers it as pc, and tracks taken jumps and self-loop halts.
module program_sequencer #(
  parameter logic [7:0] RESET_ADDR   = 8'h00,
  parameter int         TARGET_SHIFT = 4
) (
  input  logic       clk,
  input  logic       sync_reset,
  input  logic       jmp,
  input  logic       jmp_nz,
  input  logic [3:0] jmp_addr,
  input  logic       dont_jmp,
  input  logic       hold,
  output logic [7:0] pm_addr,
  output logic [7:0] pc,
  output logic [7:0] taken_count,
  output logic       halted,
  output logic [7:0] from_PS
);

  logic [7:0] target;
  logic       jump_req;
  logic       taken;

  assign target   = 8'({4'h0, jmp_addr} << TARGET_SHIFT);
  assign jump_req = jmp | (jmp_nz & ~dont_jmp);
  assign taken    = ~sync_reset & ~hold & jump_req;
  assign from_PS  = pc;

  // Fetch-address priority mux: reset, stall, jump, then sequential.
  always_comb begin
    pm_addr = pc + 8'd1;
    if (sync_reset) begin
      pm_addr = RESET_ADDR;
    end else if (hold) begin
      pm_addr = pc;
    end else if (jump_req) begin
      pm_addr = target;
    end else begin
      pm_addr = pc + 8'd1;
    end
  end

  // State registers; a stall freezes the counter and halt flag.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pc          <= RESET_ADDR;
      taken_count <= 8'h00;
      halted      <= 1'b0;
    end else begin
      pc <= pm_addr;
      if (taken && (taken_count != 8'hFF)) begin
        taken_count <= taken_count + 8'd1;
      end else begin
        taken_count <= taken_count;
      end
      if (hold) begin
        halted <= halted;
      end else if (taken && (target == pc)) begin
        halted <= 1'b1;
      end else if (pm_addr != pc) begin
        halted <= 1'b0;
      end else begin
        halted <= halted;
      end
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer with hand-computed expectations.
module tb_program_sequencer;

  logic       clk;
  logic       sync_reset;
  logic       jmp;
  logic       jmp_nz;
  logic [3:0] jmp_addr;
  logic       dont_jmp;
  logic       hold;
  logic [7:0] pm_addr;
  logic [7:0] pc;
  logic [7:0] taken_count;
  logic       halted;
  logic [7:0] from_PS;

  int tests_run;
  int tests_failed;

  program_sequencer dut (
    .clk         (clk),
    .sync_reset  (sync_reset),
    .jmp         (jmp),
    .jmp_nz      (jmp_nz),
    .jmp_addr    (jmp_addr),
    .dont_jmp    (dont_jmp),
    .hold        (hold),
    .pm_addr     (pm_addr),
    .pc          (pc),
    .taken_count (taken_count),
    .halted      (halted),
    .from_PS     (from_PS)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_cnt;
    tests_run    = 0;
    tests_failed = 0;
    sync_reset = 1'b1;
    jmp        = 1'b0;
    jmp_nz     = 1'b0;
    jmp_addr   = 4'h0;
    dont_jmp   = 1'b0;
    hold       = 1'b0;

    // Reset state
    tick();
    check("rst_pc", pc, 8'h00);
    check("rst_cnt", taken_count, 8'h00);
    check("rst_halt", {7'b0, halted}, 8'h00);
    check("rst_from_ps", from_PS, 8'h00);
    check("rst_pm", pm_addr, 8'h00);
    sync_reset = 1'b0;
    #1;
    check("first_fetch", pm_addr, 8'h01);

    // Free-run with wrap
    for (int i = 1; i <= 260; i++) begin
      tick();
      check("free_pc", pc, 8'(i));
    end
    check("free_cnt", taken_count, 8'h00);
    check("free_halt", {7'b0, halted}, 8'h00);
    check("free_from_ps", from_PS, 8'h04);
    tick();
    check("pre_jmp_pc", pc, 8'h05);

    // Unconditional jump
    jmp = 1'b1; jmp_addr = 4'h3;
    #1;
    check("jmp_pm", pm_addr, 8'h30);
    tick();
    check("jmp_pc", pc, 8'h30);
    check("jmp_cnt", taken_count, 8'h01);
    jmp = 1'b0;

    // Conditional jump suppressed, then taken
    jmp_nz = 1'b1; jmp_addr = 4'h2; dont_jmp = 1'b1;
    #1;
    check("jnz_sup_pm", pm_addr, 8'h31);
    tick();
    check("jnz_sup_pc", pc, 8'h31);
    check("jnz_sup_cnt", taken_count, 8'h01);
    dont_jmp = 1'b0;
    #1;
    check("jnz_pm", pm_addr, 8'h20);
    tick();
    check("jnz_pc", pc, 8'h20);
    check("jnz_cnt", taken_count, 8'h02);
    jmp_nz = 1'b0;

    // Self-loop halt at 0x40
    jmp = 1'b1; jmp_addr = 4'h4;
    tick();
    check("to40_pc", pc, 8'h40);
    check("to40_cnt", taken_count, 8'h03);
    check("to40_halt", {7'b0, halted}, 8'h00);
    #1;
    check("loop_pm", pm_addr, 8'h40);
    tick();
    check("halt_set", {7'b0, halted}, 8'h01);
    check("halt_cnt", taken_count, 8'h04);
    tick();
    check("halt_keep", {7'b0, halted}, 8'h01);
    check("halt_cnt2", taken_count, 8'h05);

    // Stall with a jump pending: everything frozen
    hold = 1'b1;
    #1;
    check("hold_pm", pm_addr, 8'h40);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_pc", pc, 8'h40);
      check("hold_cnt", taken_count, 8'h05);
      check("hold_halt", {7'b0, halted}, 8'h01);
    end
    hold = 1'b0; jmp = 1'b0;
    #1;
    check("unhalt_pm", pm_addr, 8'h41);
    tick();
    check("unhalt_pc", pc, 8'h41);
    check("unhalt_halt", {7'b0, halted}, 8'h00);
    check("unhalt_cnt", taken_count, 8'h05);

    // Reset during hold overrides stall and pending jump
    hold = 1'b1; jmp = 1'b1; jmp_addr = 4'h7;
    #1;
    check("hold2_pm", pm_addr, 8'h41);
    tick();
    check("hold2_pc", pc, 8'h41);
    sync_reset = 1'b1;
    #1;
    check("rst_hold_pm", pm_addr, 8'h00);
    tick();
    check("rst_hold_pc", pc, 8'h00);
    check("rst_hold_cnt", taken_count, 8'h00);
    sync_reset = 1'b0; hold = 1'b0; jmp = 1'b0;

    // jmp and jmp_nz together: jmp wins despite dont_jmp
    jmp = 1'b1; jmp_nz = 1'b1; dont_jmp = 1'b1; jmp_addr = 4'h5;
    #1;
    check("both_pm", pm_addr, 8'h50);
    tick();
    check("both_pc", pc, 8'h50);
    check("both_cnt", taken_count, 8'h01);
    jmp_nz = 1'b0; dont_jmp = 1'b0;

    // 300 taken jumps: saturation
    jmp_addr = 4'h1;
    exp_cnt = 8'h01;
    for (int i = 0; i < 300; i++) begin
      tick();
      exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
      check("sat_cnt", taken_count, exp_cnt);
    end
    check("sat_final", taken_count, 8'hFF);
    check("sat_halt", {7'b0, halted}, 8'h01);
    jmp = 1'b0;
    tick();
    check("sat_hold_cnt", taken_count, 8'hFF);
    check("sat_pc", pc, 8'h11);
    check("sat_unhalt", {7'b0, halted}, 8'h00);
    sync_reset = 1'b1;
    tick();
    check("sat_rst_cnt", taken_count, 8'h00);
    sync_reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Program-counter stage directly upstream of the instruction decoder. Each cycle it computes the program-memory fetch address `pm_addr` from the current `pc`, the decoder's jump controls and the zero flag from the computational unit. It registers that address into `pc`, so `pc` always tags the instruction the decoder holds in `ir`. It also provides a stall input, a saturating taken-jump counter, a self-loop (halt) detector and an 8-bit exam/debug hook.

## Interface
Parameters:
- `RESET_ADDR`, default 8'h00: fetch address forced during reset.
- `TARGET_SHIFT`, default 4: jump target is `jmp_addr` shifted left by this amount, zero-filled.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `sync_reset`  in  1  synchronous, active-high reset.
- `jmp`  in  1  unconditional jump for the instruction in `ir` (from decoder).
- `jmp_nz`  in  1  conditional jump for the instruction in `ir` (from decoder).
- `jmp_addr`  in  4  jump target nibble (decoder `ir_nibble`).
- `dont_jmp`  in  1  zero flag from the computational unit; 1 suppresses `jmp_nz`.
- `hold`  in  1  stall: re-fetch the current address and freeze all state.
- `pm_addr`  out  8  combinational program-memory address.
- `pc`  out  8  registered address of the instruction currently in `ir`.
- `taken_count`  out  8  saturating count of taken jumps.
- `halted`  out  1  set when a taken jump targets its own address.
- `from_PS`  out  8  debug hook; equals `pc`.

## Operation
Target: `target = {jmp_addr, 4'h0}` at the default shift.

`pm_addr` is combinational. Priority, highest first:
1. `sync_reset` gives `RESET_ADDR`.
2. `hold` gives `pc`.
3. `jmp` gives `target`.
4. `jmp_nz & ~dont_jmp` gives `target`.
5. Otherwise `pc + 1`, modulo 256 (8'hFF wraps to 8'h00 silently).

Taken jump: `taken = ~sync_reset & ~hold & (jmp | (jmp_nz & ~dont_jmp))`.

If `jmp` and `jmp_nz` are both asserted (illegal from the decoder), `jmp` wins. The result is taken regardless of `dont_jmp`.

Register updates each edge:
- `pc <= pm_addr`.
- `taken_count`: +1 when `taken`, holds at 8'hFF (saturates).
- `halted` is set when `taken` and `target == pc`.
- `halted` is cleared when `~hold` and `pm_addr != pc`.
- Otherwise `halted` holds; it holds throughout `hold`.

`from_PS` is a continuous copy of `pc`.

## Timing
- Reset values, effective at the first edge with `sync_reset` = 1: `pc` = 8'h00, `taken_count` = 0, `halted` = 0, `from_PS` = 0. `pm_addr` = 8'h00 combinationally while reset is high.
- Reset mid-program overrides `hold` and pending jumps in the same cycle.
- First fetch after reset: `pm_addr` = 8'h01 in the cycle after reset deasserts. The decoder captured the instruction at 8'h00 on the reset edge.
- Zero-latency branch: a jump decoded from `ir` in cycle n puts `target` on `pm_addr` in cycle n, and `pc` = `target` at edge n+1. There is no delay slot; the instruction after the jump is never fetched.
- `dont_jmp` is sampled combinationally in the same cycle as `jmp_nz`.
- `hold` acts the cycle it is high. `pm_addr` = `pc`, so the decoder reloads the same instruction. Counters and `halted` are frozen.
- The combinational path runs from `jmp`/`jmp_nz`/`dont_jmp` to `pm_addr`. There is no combinational path from `pm_addr` back to any input.

## Test plan
- Reset then free-run, no jumps, 260 cycles → `pc` steps 00,01,…,FF,00,01,…; `taken_count` = 0; `halted` = 0.
- `pc` = 8'h05, `jmp` = 1, `jmp_addr` = 4'h3 → `pm_addr` = 8'h30 same cycle; `pc` = 8'h30 next edge; `taken_count` increments by 1.
- `jmp_nz` = 1, `jmp_addr` = 4'h2: with `dont_jmp` = 1 → `pm_addr` = `pc` + 1, count unchanged; with `dont_jmp` = 0 → `pm_addr` = 8'h20.
- `pc` = 8'h40, `jmp` = 1, `jmp_addr` = 4'h4 → `halted` = 1 next edge. Holding the jump keeps `halted` = 1 and `taken_count` rising. Removing `jmp` → `pm_addr` = 8'h41, `halted` = 0.
- `hold` = 1 for 3 cycles with `jmp` = 1 → `pc`, `taken_count` and `halted` unchanged; `pm_addr` = `pc`. `sync_reset` asserted during the hold → `pc` = 0 next edge.
- 300 consecutive taken jumps → `taken_count` saturates at 8'hFF and stays there until reset.
